// File: rtl/util_1553_pkg.sv
// Shared constants for the 1553 receive path: sync codes, word sizes, tuser layout and bus
// level encodings.
package util_1553_pkg;

    typedef logic [2:0] sync_type_t;

    localparam sync_type_t SYNC_CMD  = 3'b100;
    localparam sync_type_t SYNC_DATA = 3'b010;

    localparam int unsigned WORD_BITS        = 16;
    localparam int unsigned BITS_WITH_PARITY = 17;

    localparam int unsigned TUSER_SYNC_MSB = 7;
    localparam int unsigned TUSER_SYNC_LSB = 5;
    localparam int unsigned TUSER_PARITY   = 0;

    localparam logic [1:0] HIGH = 2'b10;
    localparam logic [1:0] LOW  = 2'b01;

    function automatic logic level_valid(input logic [1:0] lvl);
        return (lvl == HIGH) || (lvl == LOW);
    endfunction

endpackage

// File: rtl/util_1553_sync_detect.sv
// Synchronizes the bus pair and measures the two 1.5-bit sync halves. sync_found_o marks the
// first sample of data bit 0; sync_err_o exists only with UTIL_AXIS_1553_DECODER_RX_ERR_EN.
module util_1553_sync_detect
    import util_1553_pkg::*;
#(
    parameter int unsigned samples_per_bit = 20,
    parameter int unsigned sync_tol        = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] diff_i,
    input  logic       hold_i,
    output logic [1:0] diff_sync_o,
    output logic       sync_found_o,
    output logic [2:0] sync_type_o
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
    ,
    output logic       sync_err_o
`endif
);

    localparam int unsigned SyncNom = 3 * samples_per_bit / 2;
    localparam int unsigned SyncMin = SyncNom - sync_tol;
    localparam int unsigned SyncMax = SyncNom + sync_tol;
    localparam int unsigned RunW    = $clog2(SyncMax + 2);

    localparam logic [RunW-1:0] RunNom = RunW'(SyncNom);
    localparam logic [RunW-1:0] RunMin = RunW'(SyncMin);
    localparam logic [RunW-1:0] RunMax = RunW'(SyncMax);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StSyncA = 2'd1;
    localparam logic [1:0] StSyncB = 2'd2;

    logic [1:0]      meta_q, sync_q;
    logic [1:0]      state_q, state_d;
    logic [RunW-1:0] run_q, run_d;
    logic [1:0]      level_q, level_d;
    sync_type_t      type_q, type_d;
    logic            valid, same, in_win, sync_bad;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q  <= '0;
            sync_q  <= '0;
            state_q <= StIdle;
            run_q   <= '0;
            level_q <= '0;
            type_q  <= '0;
        end else begin
            meta_q  <= diff_i;
            sync_q  <= meta_q;
            state_q <= state_d;
            run_q   <= run_d;
            level_q <= level_d;
            type_q  <= type_d;
        end
    end

    assign valid    = level_valid(sync_q);
    assign same     = (sync_q == level_q);
    assign in_win   = (run_q >= RunMin) && (run_q <= RunMax);
    assign sync_bad = !hold_i && (state_q == StSyncB) && (!valid || (!same && !in_win));

    always_comb begin
        state_d      = state_q;
        run_d        = run_q;
        level_d      = level_q;
        type_d       = type_q;
        sync_found_o = 1'b0;
        if (hold_i) begin
            state_d = StIdle;
            run_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (valid) begin
                        level_d = sync_q;
                        run_d   = RunW'(1);
                        state_d = StSyncA;
                    end
                end
                StSyncA: begin
                    if (!valid) begin
                        state_d = StIdle;
                        run_d   = '0;
                    end else if (same) begin
                        // Saturate so an over-long run can never alias into a valid sync.
                        if (run_q <= RunMax) run_d = run_q + 1'b1;
                    end else if (in_win) begin
                        type_d  = (level_q == HIGH) ? SYNC_CMD : SYNC_DATA;
                        level_d = sync_q;
                        run_d   = RunW'(1);
                        state_d = StSyncB;
                    end else begin
                        level_d = sync_q;
                        run_d   = RunW'(1);
                    end
                end
                StSyncB: begin
                    // Bit 0 may continue the second half's level, so a nominal-length run
                    // with no edge also marks the start of data.
                    if (sync_bad) begin
                        state_d = StIdle;
                        run_d   = '0;
                    end else if (!same || (run_q == RunNom)) begin
                        sync_found_o = 1'b1;
                        state_d      = StIdle;
                        run_d        = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    run_d   = '0;
                end
            endcase
        end
    end

    assign diff_sync_o = sync_q;
    assign sync_type_o = type_q;

`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
    assign sync_err_o = sync_bad;
`endif

endmodule

// File: rtl/util_axis_1553_decoder.sv
// MIL-STD-1553 receive decoder: sync detection, Manchester decode and an AXI-Stream output
// register. Defining UTIL_AXIS_1553_DECODER_RX_ERR_EN adds the rx_err error pulse port.
module util_axis_1553_decoder
    import util_1553_pkg::*;
#(
    parameter int unsigned clock_speed = 20000000,
    parameter int unsigned sync_tol    = 2
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic [1:0]  diff,
    output logic [15:0] m_axis_tdata,
    output logic [7:0]  m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
    ,
    output logic        rx_err
`endif
);

    localparam int unsigned samples_per_bit = clock_speed / 1000000;
    localparam int unsigned TimW            = $clog2(samples_per_bit);

    localparam logic [TimW-1:0] TimFirst  = TimW'(samples_per_bit / 4);
    localparam logic [TimW-1:0] TimSecond = TimW'(3 * samples_per_bit / 4);
    localparam logic [TimW-1:0] TimLast   = TimW'(samples_per_bit - 1);
    localparam logic [4:0]      LastBit   = 5'(BITS_WITH_PARITY - 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StOutput = 2'd2;
    localparam logic [1:0] StTail   = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic [TimW-1:0]             timer_q, timer_d;
    logic [4:0]                  bit_cnt_q, bit_cnt_d;
    logic [BITS_WITH_PARITY-1:0] shift_q, shift_d;
    logic [1:0]                  half_q, half_d;
    sync_type_t                  type_q, type_d;
    logic [WORD_BITS-1:0]        tdata_q, tdata_d;
    logic [7:0]                  tuser_q, tuser_d;
    logic                        tvalid_q, tvalid_d;

    logic [1:0] diff_sync;
    logic       sync_found;
    sync_type_t sync_type;
    logic       bit_sample, manch_err, out_cycle, load;

`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
    logic sync_err;
    logic err_q;
`endif

    util_1553_sync_detect #(
        .samples_per_bit(samples_per_bit),
        .sync_tol       (sync_tol)
    ) u_sync_detect (
        .clk_i       (aclk),
        .rst_i       (arst),
        .diff_i      (diff),
        .hold_i      (state_q != StIdle),
        .diff_sync_o (diff_sync),
        .sync_found_o(sync_found),
        .sync_type_o (sync_type)
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
        ,
        .sync_err_o  (sync_err)
`endif
    );

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q   <= StIdle;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            half_q    <= '0;
            type_q    <= '0;
            tdata_q   <= '0;
            tuser_q   <= '0;
            tvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            half_q    <= half_d;
            type_q    <= type_d;
            tdata_q   <= tdata_d;
            tuser_q   <= tuser_d;
            tvalid_q  <= tvalid_d;
        end
    end

    assign bit_sample = (state_q == StData) && (timer_q == TimSecond);
    assign manch_err  = bit_sample && (!level_valid(half_q) || !level_valid(diff_sync) ||
                                       (half_q == diff_sync));
    assign out_cycle  = (state_q == StOutput);
    assign load       = out_cycle && (!tvalid_q || m_axis_tready);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        half_d    = half_q;
        type_d    = type_q;
        if (state_q != StIdle) timer_d = (timer_q == TimLast) ? '0 : timer_q + 1'b1;
        case (state_q)
            StIdle: begin
                // The sync_found sample is bit 0's sample 0, so the timer resumes at 1.
                if (sync_found) begin
                    timer_d   = TimW'(1);
                    bit_cnt_d = '0;
                    type_d    = sync_type;
                    state_d   = StData;
                end
            end
            StData: begin
                if (timer_q == TimFirst) half_d = diff_sync;
                if (manch_err) begin
                    state_d = StIdle;
                end else if (bit_sample) begin
                    shift_d   = {shift_q[BITS_WITH_PARITY-2:0], half_q == HIGH};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) state_d = StOutput;
                end
            end
            // Hold the sync detector off until the parity bit has fully elapsed so a
            // back-to-back sync is measured from its true start.
            StOutput: state_d = (timer_q == TimLast) ? StIdle : StTail;
            StTail:   if (timer_q == TimLast) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q;
        if (load) begin
            tdata_d                                = shift_q[BITS_WITH_PARITY-1:1];
            tuser_d                                = '0;
            tuser_d[TUSER_SYNC_MSB:TUSER_SYNC_LSB] = type_q;
            tuser_d[TUSER_PARITY]                  = ^shift_q;
            tvalid_d                               = 1'b1;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;

`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) err_q <= 1'b0;
        else      err_q <= sync_err | manch_err | (out_cycle && !load);
    end

    assign rx_err = err_q;
`endif

endmodule

// File: tb/tb_util_axis_1553_decoder.sv
// Directed bench for util_axis_1553_decoder: encodes words at the pin (20 samples per bit)
// and checks the decoded AXI-Stream output against hand-computed values.
module tb_util_axis_1553_decoder;

    logic        tb_data_clk = 1'b0;
    logic        arst;
    logic [1:0]  diff;
    logic [15:0] m_axis_tdata;
    logic [7:0]  m_axis_tuser;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
    logic        rx_err;
    int          err_pulses = 0;
`endif

    int   checks    = 0;
    int   errors    = 0;
    int   xfer_cnt  = 0;
    logic valid_before_end;

    util_axis_1553_decoder #(
        .clock_speed(20000000),
        .sync_tol   (2)
    ) dut (
        .aclk         (tb_data_clk),
        .arst         (arst),
        .diff         (diff),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready)
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
        ,
        .rx_err       (rx_err)
`endif
    );

    always #5 tb_data_clk = ~tb_data_clk;

    always @(posedge tb_data_clk) begin
        if (m_axis_tvalid && m_axis_tready) xfer_cnt <= xfer_cnt + 1;
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
        if (rx_err) err_pulses <= err_pulses + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge tb_data_clk);
            #1 diff = 2'b00;
        end
    endtask

    task automatic pulse_ready();
        @(posedge tb_data_clk);
        #1 m_axis_tready = 1'b1;
        @(posedge tb_data_clk);
        #1 m_axis_tready = 1'b0;
    endtask

    // Pin-level encoder: 30+30 sample sync, then 17 Manchester bits of 10+10 samples.
    task automatic send_word(input logic [15:0] w, input logic cmd, input logic flip_par,
                             input int bad_bit, input logic ready_at_land, input int cut);
        logic [1:0]  wave [400];
        logic [16:0] bits;
        logic [1:0]  first, second;
        bits = {w, (~^w) ^ flip_par};
        for (int i = 0; i < 30; i++) begin
            wave[i]      = cmd ? 2'b10 : 2'b01;
            wave[i + 30] = cmd ? 2'b01 : 2'b10;
        end
        for (int k = 0; k < 17; k++) begin
            first  = bits[16 - k] ? 2'b10 : 2'b01;
            second = bits[16 - k] ? 2'b01 : 2'b10;
            if (k == bad_bit) second = first;
            for (int j = 0; j < 10; j++) begin
                wave[60 + 20 * k + j]      = first;
                wave[60 + 20 * k + 10 + j] = second;
            end
        end
        for (int i = 0; i < cut; i++) begin
            @(posedge tb_data_clk);
            #1 diff = wave[i];
            if (i == 398) begin
                valid_before_end = m_axis_tvalid;
                if (ready_at_land) m_axis_tready = 1'b1;
            end
            if (i == 399 && ready_at_land) m_axis_tready = 1'b0;
        end
    endtask

    initial begin
        arst          = 1'b1;
        diff          = 2'b00;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge tb_data_clk);
        #1;
        check("reset_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("reset_tdata", 32'(m_axis_tdata), 32'h0);
        check("reset_tuser", 32'(m_axis_tuser), 32'h0);
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
        check("reset_rx_err", 32'(rx_err), 32'h0);
`endif
        arst = 1'b0;

        idle(100);
        check("idle_no_output", 32'(m_axis_tvalid), 32'h0);

        send_word(16'hABCD, 1'b1, 1'b0, -1, 1'b0, 400);
        check("abcd_latency", 32'(valid_before_end), 32'h0);
        check("abcd_tvalid", 32'(m_axis_tvalid), 32'h1);
        check("abcd_tdata", 32'(m_axis_tdata), 32'hABCD);
        check("abcd_tuser", 32'(m_axis_tuser), 32'h81);
        pulse_ready();
        check("abcd_cleared", 32'(m_axis_tvalid), 32'h0);
        check("abcd_xfers", 32'(xfer_cnt), 32'd1);

        idle(20);
        send_word(16'h0000, 1'b0, 1'b0, -1, 1'b0, 400);
        check("zero_tvalid", 32'(m_axis_tvalid), 32'h1);
        check("zero_tdata", 32'(m_axis_tdata), 32'h0000);
        check("zero_tuser", 32'(m_axis_tuser), 32'h41);
        pulse_ready();

        idle(20);
        send_word(16'h1234, 1'b1, 1'b1, -1, 1'b0, 400);
        check("parity_tdata", 32'(m_axis_tdata), 32'h1234);
        check("parity_tuser", 32'(m_axis_tuser), 32'h80);
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
        check("parity_no_err", 32'(err_pulses), 32'd0);
`endif
        pulse_ready();
        check("parity_xfers", 32'(xfer_cnt), 32'd3);

        idle(20);
        send_word(16'hAAAA, 1'b1, 1'b0, 5, 1'b0, 400);
        idle(20);
        check("manch_no_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("manch_xfers", 32'(xfer_cnt), 32'd3);
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
        check("manch_err_pulse", 32'(err_pulses), 32'd1);
`endif
        send_word(16'h5555, 1'b0, 1'b0, -1, 1'b0, 400);
        check("recover_tdata", 32'(m_axis_tdata), 32'h5555);
        check("recover_tuser", 32'(m_axis_tuser), 32'h41);
        pulse_ready();

        idle(20);
        send_word(16'h0001, 1'b1, 1'b0, -1, 1'b0, 400);
        send_word(16'h0002, 1'b0, 1'b0, -1, 1'b0, 400);
        idle(20);
        check("overrun_tvalid", 32'(m_axis_tvalid), 32'h1);
        check("overrun_tdata", 32'(m_axis_tdata), 32'h0001);
        check("overrun_tuser", 32'(m_axis_tuser), 32'h81);
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
        check("overrun_err_pulse", 32'(err_pulses), 32'd2);
`endif
        @(posedge tb_data_clk);
        #1 m_axis_tready = 1'b1;
        repeat (5) @(posedge tb_data_clk);
        #1 m_axis_tready = 1'b0;
        check("overrun_one_xfer", 32'(xfer_cnt), 32'd5);
        check("overrun_drained", 32'(m_axis_tvalid), 32'h0);

        idle(20);
        send_word(16'h0F0F, 1'b1, 1'b0, -1, 1'b0, 400);
        send_word(16'h00FF, 1'b0, 1'b0, -1, 1'b1, 400);
        check("nobubble_held", 32'(valid_before_end), 32'h1);
        check("nobubble_tvalid", 32'(m_axis_tvalid), 32'h1);
        check("nobubble_tdata", 32'(m_axis_tdata), 32'h00FF);
        check("nobubble_tuser", 32'(m_axis_tuser), 32'h41);
        check("nobubble_xfers", 32'(xfer_cnt), 32'd6);

        idle(20);
        send_word(16'h1357, 1'b1, 1'b0, -1, 1'b0, 225);
        #2 arst = 1'b1;
        #1;
        check("arst_tvalid", 32'(m_axis_tvalid), 32'h0);
        check("arst_tdata", 32'(m_axis_tdata), 32'h0);
        check("arst_tuser", 32'(m_axis_tuser), 32'h0);
        diff = 2'b00;
        repeat (3) @(posedge tb_data_clk);
        #1 arst = 1'b0;
        idle(20);
        send_word(16'hFFFF, 1'b1, 1'b0, -1, 1'b0, 400);
        check("post_reset_tvalid", 32'(m_axis_tvalid), 32'h1);
        check("post_reset_tdata", 32'(m_axis_tdata), 32'hFFFF);
        check("post_reset_tuser", 32'(m_axis_tuser), 32'h81);
        pulse_ready();
        check("post_reset_xfers", 32'(xfer_cnt), 32'd7);
`ifdef UTIL_AXIS_1553_DECODER_RX_ERR_EN
        check("final_err_pulses", 32'(err_pulses), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
